crossover_mask_gen: RTL

CROSSOVER_MASK_GEN -- requirements
Module: crossover_mask_gen

---
 rtl/crossover_pkg.sv | 19 +
 rtl/crossover_lfsr.sv | 38 +++
 rtl/crossover_mask_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/crossover_pkg.sv
// Shared types and constants for the crossover mask generator.
// State encoding, default sizes, LFSR taps and reset seed.
package crossover_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE
  } state_e;

  localparam int N_GENES_DEF = 16;
  localparam int PROB_W_DEF  = 4;
  localparam int LFSR_W_DEF  = 16;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_RST_SEED = 16'hACE1;

endpackage

// File: rtl/crossover_lfsr.sv
// Galois LFSR with seed load; a zero seed maps to the reset seed
// so the generator can never lock up in the all-zero state.
module crossover_lfsr
  import crossover_pkg::*;
#(
  parameter int W = LFSR_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);
  localparam logic [W-1:0] RSTV = W'(LFSR_RST_SEED);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == '0) ? RSTV : seed;
    end else if (en) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= RSTV;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/crossover_mask_gen.sv
// Crossover mask generator: one gene per cycle, multi-point toggling.
// Define CROSSOVER_UNIFORM_EN to add the uniform-crossover mode port.
module crossover_mask_gen
  import crossover_pkg::*;
#(
  parameter int N_GENES = N_GENES_DEF,
  parameter int PROB_W  = PROB_W_DEF,
  parameter int LFSR_W  = LFSR_W_DEF,
  localparam int CW     = $clog2(N_GENES + 1),
  localparam int IW     = $clog2(N_GENES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bias,
  input  logic [PROB_W-1:0] prob,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
`ifdef CROSSOVER_UNIFORM_EN
  input  logic              mode,
`endif
  output logic              busy,
  output logic              done,
  output logic [N_GENES-1:0] mask,
  output logic [CW-1:0]     cut_count
);

  localparam logic [IW-1:0] LAST = IW'(N_GENES - 1);

  state_e             state_q, state_d;
  logic               bias_q, bias_d;
  logic [PROB_W-1:0]  prob_q, prob_d;
  logic               src_q, src_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N_GENES-1:0] work_q, work_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_GENES-1:0] mask_q, mask_d;
  logic [CW-1:0]      cc_q, cc_d;

  logic [LFSR_W-1:0]  rnd_full;
  logic [PROB_W-1:0]  rnd;
  logic               cut;
  logic               src_cur;
  logic               src_nxt;
  logic               gene_bit;
  logic               uni;
  logic               lfsr_en;
  logic               lfsr_load;
  logic               unused_rnd_hi;

  assign lfsr_en   = (state_q == GEN);
  assign lfsr_load = seed_load && (state_q == IDLE);

  crossover_lfsr #(
    .W(LFSR_W)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .load (lfsr_load),
    .seed (seed),
    .value(rnd_full)
  );

  assign rnd           = rnd_full[PROB_W-1:0];
  assign unused_rnd_hi = ^rnd_full;
  assign cut           = (rnd < prob_q);

`ifdef CROSSOVER_UNIFORM_EN
  logic mode_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            mode_q <= 1'b0;
    else if (state_q == IDLE && start)  mode_q <= mode;
  end
  assign uni = mode_q;
`else
  assign uni = 1'b0;
`endif

  // Gene 0 starts from the captured bias rather than the stale source
  assign src_cur  = (idx_q == '0) ? bias_q : src_q;
  assign src_nxt  = cut ? ~src_cur : src_cur;
  assign gene_bit = uni ? (cut ? ~bias_q : bias_q) : src_nxt;

  always_comb begin
    state_d = state_q;
    bias_d  = bias_q;
    prob_d  = prob_q;
    src_d   = src_q;
    idx_d   = idx_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    cc_d    = cc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GEN;
          bias_d  = bias;
          prob_d  = prob;
          idx_d   = '0;
          work_d  = '0;
          cnt_d   = '0;
        end
      end
      GEN: begin
        src_d         = src_nxt;
        work_d[idx_q] = gene_bit;
        cnt_d         = cnt_q + CW'(cut);
        if (idx_q == LAST) begin
          state_d = DONE;
          mask_d  = work_d;
          cc_d    = cnt_d;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bias_q  <= 1'b0;
      prob_q  <= '0;
      src_q   <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      bias_q  <= bias_d;
      prob_q  <= prob_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cc_q    <= cc_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mask      = mask_q;
  assign cut_count = cc_q;

endmodule
